// File: rtl/console_pkg.sv
// console_pkg: screen geometry, control bytes, writer states and address helpers
package console_pkg;
    localparam int COLUMNS = 80;
    localparam int ROWS    = 30;
    localparam int CELL_W  = 8;
    localparam int CELL_H  = 16;
    localparam int CELLS   = ROWS * COLUMNS;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    typedef enum logic [1:0] {CLEAR_ALL, IDLE, CLEAR_LINE} text_state_t;

    // prow*80 + col built from shifts so no multiplier is inferred
    function automatic logic [11:0] cell_addr(input logic [4:0] prow, input logic [6:0] col);
        return ({7'd0, prow} << 6) + ({7'd0, prow} << 4) + {5'd0, col};
    endfunction

    // Logical row plus scroll offset, folded back into 0..ROWS-1 with one subtract
    function automatic logic [4:0] phys_row(input logic [5:0] lrow, input logic [4:0] top);
        logic [6:0] s;
        s = {1'b0, lrow} + {2'b0, top};
        s = (s >= 7'(ROWS)) ? s - 7'(ROWS) : s;
        return s[4:0];
    endfunction
endpackage

// File: rtl/console_text_buffer_if.sv
// console_text_buffer_if: host byte stream, clear pulse and cursor feedback
interface console_text_buffer_if;
    logic [7:0] char_in;
    logic [7:0] attr_in;
    logic       char_valid;
    logic       char_ready;
    logic       clear;
    logic [6:0] cursor_col;
    logic [4:0] cursor_row;

    modport master (
        output char_in, attr_in, char_valid, clear,
        input  char_ready, cursor_col, cursor_row
    );

    modport slave (
        input  char_in, attr_in, char_valid, clear,
        output char_ready, cursor_col, cursor_row
    );
endinterface

// File: rtl/text_ram.sv
// text_ram: simple dual-port cell store, registered read returning old data on collision
module text_ram
    import console_pkg::*;
(
    input  logic        clk_pixel,
    input  logic        we,
    input  logic [11:0] waddr,
    input  logic [15:0] wdata,
    input  logic [11:0] raddr,
    output logic [15:0] rdata
);
    logic [15:0] mem [CELLS];

    // One write and one registered read per cycle; contents are never reset
    always_ff @(posedge clk_pixel) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/console_text_buffer.sv
// console_text_buffer: 80x30 text screen with terminal-style writer and scroll offset
module console_text_buffer
    import console_pkg::*;
#(
    parameter logic [7:0] DEFAULT_ATTR = 8'h07
) (
    input  logic                  clk_pixel,
    input  logic                  RESETn,
    input  logic [9:0]            cx,
    input  logic [9:0]            cy,
    output logic [7:0]            character,
    output logic [7:0]            attribute,
    console_text_buffer_if.slave  host
);
    text_state_t state, state_d;
    logic [11:0] cnt, cnt_d;
    logic [6:0]  col, col_d;
    logic [4:0]  row, row_d, top_row, top_d, last_row;
    logic        we, accept, newline, visible, vis1, vis2;
    logic [11:0] waddr, rd_addr;
    logic [15:0] wdata, rdata;

    text_ram u_ram (
        .clk_pixel (clk_pixel),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .raddr     (rd_addr),
        .rdata     (rdata)
    );

    assign visible          = (cx < 10'(COLUMNS * CELL_W)) && (cy < 10'(ROWS * CELL_H));
    assign {character, attribute} = vis2 ? rdata : 16'h0000;
    assign host.char_ready  = (state == IDLE) && !host.clear;
    assign host.cursor_col  = col;
    assign host.cursor_row  = row;
    assign accept           = host.char_valid && host.char_ready;
    assign last_row         = (top_row == 5'd0) ? 5'(ROWS - 1) : top_row - 5'd1;

    // Read pipeline: register the cell address, then carry the visibility flag alongside the RAM read
    always_ff @(posedge clk_pixel or negedge RESETn) begin
        if (!RESETn) begin
            rd_addr <= '0;
            vis1    <= 1'b0;
            vis2    <= 1'b0;
        end else begin
            rd_addr <= visible ? cell_addr(phys_row(cy[9:4], top_row), cx[9:3]) : '0;
            vis1    <= visible;
            vis2    <= vis1;
        end
    end

    // Writer state, cursor and scroll offset registers
    always_ff @(posedge clk_pixel or negedge RESETn) begin
        if (!RESETn) begin
            state   <= CLEAR_ALL;
            cnt     <= '0;
            col     <= '0;
            row     <= '0;
            top_row <= '0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            col     <= col_d;
            row     <= row_d;
            top_row <= top_d;
        end
    end

    // Writer next state: blanking sweeps, byte interpretation, wrap and scroll; clear overrides all
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        col_d   = col;
        row_d   = row;
        top_d   = top_row;
        we      = 1'b0;
        waddr   = cnt;
        wdata   = {ASCII_SPACE, DEFAULT_ATTR};
        newline = 1'b0;
        case (state)
            CLEAR_ALL: begin
                we    = 1'b1;
                cnt_d = cnt + 12'd1;
                if (cnt == 12'(CELLS - 1)) state_d = IDLE;
            end
            CLEAR_LINE: begin
                we    = 1'b1;
                waddr = cell_addr(last_row, cnt[6:0]);
                cnt_d = cnt + 12'd1;
                if (cnt == 12'(COLUMNS - 1)) state_d = IDLE;
            end
            default: if (accept) begin
                if (host.char_in == ASCII_CR) col_d = '0;
                else if (host.char_in == ASCII_LF) newline = 1'b1;
                else begin
                    we      = 1'b1;
                    waddr   = cell_addr(phys_row({1'b0, row}, top_row), col);
                    wdata   = {host.char_in, host.attr_in};
                    col_d   = col + 7'd1;
                    newline = (col == 7'(COLUMNS - 1));
                end
                if (newline) begin
                    col_d = '0;
                    cnt_d = '0;
                    if (row < 5'(ROWS - 1)) row_d = row + 5'd1;
                    else begin
                        top_d   = (top_row == 5'(ROWS - 1)) ? 5'd0 : top_row + 5'd1;
                        state_d = CLEAR_LINE;
                    end
                end
            end
        endcase
        if (host.clear) begin
            state_d = CLEAR_ALL;
            cnt_d   = '0;
            col_d   = '0;
            row_d   = '0;
            top_d   = '0;
        end
    end
endmodule

// File: tb/tb_console_text_buffer.sv
// tb_console_text_buffer: scoreboard-checked reads against a logical screen model, plus table vectors
module tb_console_text_buffer;
    import console_pkg::*;

    logic       clk_pixel = 1'b0;
    logic       RESETn = 1'b0;
    logic [9:0] cx = '0, cy = '0;
    logic [7:0] character, attribute;

    console_text_buffer_if bus ();

    console_text_buffer dut (
        .clk_pixel (clk_pixel),
        .RESETn    (RESETn),
        .cx        (cx),
        .cy        (cy),
        .character (character),
        .attribute (attribute),
        .host      (bus)
    );

    always #5 clk_pixel = ~clk_pixel;

    typedef struct {logic [9:0] x; logic [9:0] y; logic [15:0] exp; int due;} sb_t;
    typedef struct {logic [9:0] x; logic [9:0] y; logic [7:0] ch; logic [7:0] at;} vec_t;

    int          n_vec = 0, n_err = 0, cyc = 0;
    sb_t         sb[$];
    sb_t         e;
    logic [15:0] scr [ROWS][COLUMNS];
    int          mcol, mrow;

    task automatic tick;
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Read results are due exactly two clock edges after the coordinates are presented
    always begin
        @(posedge clk_pixel);
        cyc++;
        #2;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            n_vec++;
            if ({character, attribute} !== e.exp || e.due != cyc) begin
                n_err++;
                $display("FAIL read cx=%0d cy=%0d: got %h/%h, expected %h/%h",
                         e.x, e.y, character, attribute, e.exp[15:8], e.exp[7:0]);
            end
        end
    end

    task automatic rd(input int x, input int y, input logic [15:0] exp);
        cx = 10'(x);
        cy = 10'(y);
        sb.push_back('{10'(x), 10'(y), exp, cyc + 2});
        tick;
    endtask

    task automatic model_blank;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLUMNS; c++) scr[r][c] = 16'h2007;
        mcol = 0;
        mrow = 0;
    endtask

    task automatic model_newline;
        mcol = 0;
        if (mrow < ROWS - 1) mrow++;
        else begin
            for (int r = 0; r < ROWS - 1; r++)
                for (int c = 0; c < COLUMNS; c++) scr[r][c] = scr[r + 1][c];
            for (int c = 0; c < COLUMNS; c++) scr[ROWS - 1][c] = 16'h2007;
        end
    endtask

    task automatic wait_ready(input string name, input int exp);
        int n = 0;
        while (!bus.char_ready && n < 5000) begin
            n++;
            tick;
        end
        chk(name, n, exp);
    endtask

    task automatic send(input logic [7:0] c, input logic [7:0] a);
        int n = 0;
        while (!bus.char_ready && n < 3000) begin
            n++;
            tick;
        end
        if (!bus.char_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL send timeout: char_ready %0d after %0d cycles, expected 1", bus.char_ready, n);
        end
        bus.char_in    = c;
        bus.attr_in    = a;
        bus.char_valid = 1'b1;
        tick;
        bus.char_valid = 1'b0;
        if (c == ASCII_CR) mcol = 0;
        else if (c == ASCII_LF) model_newline;
        else begin
            scr[mrow][mcol] = {c, a};
            if (mcol == COLUMNS - 1) model_newline;
            else mcol++;
        end
    endtask

    task automatic verify_screen;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLUMNS; c++)
                rd(c * 8 + int'($urandom_range(0, 7)), r * 16 + int'($urandom_range(0, 15)), scr[r][c]);
        tick;
        tick;
    endtask

    task automatic chk_cursor(input string name, input int c, input int r);
        chk({name, " col"}, int'(bus.cursor_col), c);
        chk({name, " row"}, int'(bus.cursor_row), r);
    endtask

    initial begin
        vec_t tv[10];
        bus.char_in    = '0;
        bus.attr_in    = '0;
        bus.char_valid = 1'b0;
        bus.clear      = 1'b0;

        // Reset values, then the full-screen blanking sweep
        repeat (3) tick;
        chk("reset character", int'(character), 0);
        chk("reset attribute", int'(attribute), 0);
        chk("reset char_ready", int'(bus.char_ready), 0);
        chk_cursor("reset cursor", 0, 0);
        RESETn = 1'b1;
        wait_ready("reset clear cycles", 2400);
        model_blank;
        verify_screen;

        // Two bytes, then table of reads including off-screen coordinates
        send(8'h41, 8'h1F);
        send(8'h42, 8'h1F);
        chk_cursor("after AB", 2, 0);
        tv = '{'{10'd8,   10'd0,   8'h42, 8'h1F}, '{10'd0,   10'd0,   8'h41, 8'h1F},
               '{10'd15,  10'd15,  8'h42, 8'h1F}, '{10'd7,   10'd15,  8'h41, 8'h1F},
               '{10'd16,  10'd0,   8'h20, 8'h07}, '{10'd640, 10'd0,   8'h00, 8'h00},
               '{10'd0,   10'd480, 8'h00, 8'h00}, '{10'd799, 10'd524, 8'h00, 8'h00},
               '{10'd639, 10'd479, 8'h20, 8'h07}, '{10'd0,   10'd16,  8'h20, 8'h07}};
        for (int i = 0; i < 10; i++) rd(int'(tv[i].x), int'(tv[i].y), {tv[i].ch, tv[i].at});
        tick;
        tick;

        // Clear together with a byte: byte dropped, full sweep, cursor home
        bus.clear      = 1'b1;
        bus.char_valid = 1'b1;
        bus.char_in    = 8'h5A;
        bus.attr_in    = 8'h1F;
        tick;
        bus.clear      = 1'b0;
        bus.char_valid = 1'b0;
        wait_ready("clear cycles", 2400);
        chk_cursor("after clear", 0, 0);
        model_blank;
        rd(0, 0, 16'h2007);
        rd(8, 0, 16'h2007);
        rd(0, 0, 16'h2007);

        // Line wrap on the 80th byte, then CR and LF without writes
        for (int i = 0; i < 79; i++) send(8'h78, 8'h2A);
        chk_cursor("79 bytes", 79, 0);
        send(8'h78, 8'h2A);
        chk_cursor("wrap", 0, 1);
        chk("no scroll on wrap", int'(bus.char_ready), 1);
        send(ASCII_CR, 8'h2A);
        chk_cursor("after CR", 0, 1);
        send(ASCII_LF, 8'h2A);
        chk_cursor("after LF", 0, 2);
        verify_screen;

        // Fill every row with a tag, then scroll once
        bus.clear = 1'b1;
        tick;
        bus.clear = 1'b0;
        wait_ready("second clear cycles", 2400);
        model_blank;
        for (int r = 0; r < ROWS; r++) begin
            send(8'(48 + r), 8'(16 + r));
            if (r < ROWS - 1) send(ASCII_LF, 8'h00);
        end
        chk_cursor("row 29 tagged", 1, 29);
        send(ASCII_LF, 8'h00);
        wait_ready("line clear cycles", 80);
        chk_cursor("after scroll", 0, 29);
        rd(0, 0, 16'h3111);
        for (int c = 0; c < COLUMNS; c++) rd(c * 8, 464, 16'h2007);
        send(8'h51, 8'h4E);
        rd(0, 464, 16'h514E);
        verify_screen;

        // Scroll the offset around the end of the circular row space
        for (int i = 0; i < 29; i++) send(ASCII_LF, 8'h00);
        wait_ready("last line clear", 80);
        chk_cursor("after 29 scrolls", 0, 29);
        rd(0, 0, 16'h514E);
        verify_screen;

        // Reset in the middle of a clear restarts the whole sweep
        bus.clear = 1'b1;
        tick;
        bus.clear = 1'b0;
        repeat (100) tick;
        RESETn = 1'b0;
        tick;
        chk("mid-clear reset character", int'(character), 0);
        chk_cursor("mid-clear reset cursor", 0, 0);
        RESETn = 1'b1;
        wait_ready("restart clear cycles", 2400);
        rd(0, 0, 16'h2007);
        rd(632, 464, 16'h2007);

        repeat (3) tick;
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard drain: %0d reads outstanding, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
